// File: rtl/pipe_control_unit.sv
// Main pipeline controller for the 5-stage RV32 core: decodes the ID opcode into a control bundle,
// walks it through ID/EX, EX/MEM and MEM/WB, and resolves load-use stalls, branch flushes and forwarding.
module pipe_control_unit #(
  parameter int REG_AW    = 5,
  parameter bit EN_BRANCH = 1'b1,
  parameter bit EN_FWD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              branch_taken_ex,
  input  logic              hold,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              alu_src_ex,
  output logic [1:0]        alu_op_ex,
  output logic              branch_ex,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              mem_read_mem,
  output logic              mem_write_mem,
  output logic              mem_to_reg_wb,
  output logic              reg_write_wb,
  output logic [REG_AW-1:0] rd_wb
);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Unrecognised opcodes fall through to the all-zero bundle, i.e. a bubble.
  function automatic ctl_t decode(input logic [6:0] op, input logic [REG_AW-1:0] rd);
    ctl_t c;
    c = '0;
    case (op)
      OP_R:     begin c.reg_write = 1'b1; c.alu_op = 2'b10; end
      OP_I:     begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = 2'b00; end
      OP_LOAD:  begin
        c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
        c.reg_write = 1'b1; c.alu_op = 2'b01;
      end
      OP_STORE: begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = 2'b01; end
      OP_BRANCH: begin
        if (EN_BRANCH) begin
          c.branch = 1'b1;
          c.alu_op = 2'b11;
        end
      end
      default: c = '0;
    endcase
    if (rd == '0) c.reg_write = 1'b0;
    return c;
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_mem,
    input logic [REG_AW-1:0] rd_mem,
    input logic              wr_wb,
    input logic [REG_AW-1:0] rd_wbk
  );
    if (wr_mem && rd_mem != '0 && rd_mem == rs)     return 2'b10;
    else if (wr_wb && rd_wbk != '0 && rd_wbk == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  ctl_t              ctl_p0;
  logic [REG_AW-1:0] rs1_p0, rs2_p0, rd_p0;
  logic              mem_read_p1, mem_write_p1, mem_to_reg_p1, reg_write_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              mem_to_reg_p2, reg_write_p2;
  logic [REG_AW-1:0] rd_p2;

  logic flush;
  logic luh;

  assign flush = EN_BRANCH && branch_taken_ex;
  assign luh   = ctl_p0.mem_read && (rd_p0 != '0) && ((rd_p0 == rs1_id) || (rd_p0 == rs2_id));

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (flush) begin
      if_id_flush = 1'b1;
    end else if (luh) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_p0        <= '0;
      rs1_p0        <= '0;
      rs2_p0        <= '0;
      rd_p0         <= '0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
      rd_p1         <= '0;
      mem_to_reg_p2 <= 1'b0;
      reg_write_p2  <= 1'b0;
      rd_p2         <= '0;
    end else if (!hold) begin
      // ID -> EX: a squashed or stalled slot enters EX as a bubble
      if (flush || luh) begin
        ctl_p0 <= '0;
        rs1_p0 <= '0;
        rs2_p0 <= '0;
        rd_p0  <= '0;
      end else begin
        ctl_p0 <= decode(opcode_id, rd_id);
        rs1_p0 <= rs1_id;
        rs2_p0 <= rs2_id;
        rd_p0  <= rd_id;
      end
      // EX -> MEM
      mem_read_p1   <= ctl_p0.mem_read;
      mem_write_p1  <= ctl_p0.mem_write;
      mem_to_reg_p1 <= ctl_p0.mem_to_reg;
      reg_write_p1  <= ctl_p0.reg_write;
      rd_p1         <= rd_p0;
      // MEM -> WB
      mem_to_reg_p2 <= mem_to_reg_p1;
      reg_write_p2  <= reg_write_p1;
      rd_p2         <= rd_p1;
    end
  end

  assign alu_src_ex    = ctl_p0.alu_src;
  assign alu_op_ex     = ctl_p0.alu_op;
  assign branch_ex     = ctl_p0.branch;
  assign mem_read_mem  = mem_read_p1;
  assign mem_write_mem = mem_write_p1;
  assign mem_to_reg_wb = mem_to_reg_p2;
  assign reg_write_wb  = reg_write_p2;
  assign rd_wb         = rd_p2;

  assign forward_a = EN_FWD ? fwd_sel(rs1_p0, reg_write_p1, rd_p1, reg_write_p2, rd_p2) : 2'b00;
  assign forward_b = EN_FWD ? fwd_sel(rs2_p0, reg_write_p1, rd_p1, reg_write_p2, rd_p2) : 2'b00;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed vector table, reset/stall/hold sequences and random
// stimulus checked against an instruction-level model of the three pipeline slots.
module tb_pipe_control_unit;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode_id = '0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic       branch_taken_ex = 1'b0;
  logic       hold = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, alu_src_ex, branch_ex;
  logic [1:0] alu_op_ex, forward_a, forward_b;
  logic       mem_read_mem, mem_write_mem, mem_to_reg_wb, reg_write_wb;
  logic [4:0] rd_wb;

  int checks = 0;
  int failures = 0;

  pipe_control_unit #(.REG_AW(5), .EN_BRANCH(1'b1), .EN_FWD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .branch_taken_ex(branch_taken_ex), .hold(hold), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .alu_src_ex(alu_src_ex),
    .alu_op_ex(alu_op_ex), .branch_ex(branch_ex), .forward_a(forward_a), .forward_b(forward_b),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .mem_to_reg_wb(mem_to_reg_wb),
    .reg_write_wb(reg_write_wb), .rd_wb(rd_wb)
  );

  always #5 clk = ~clk;

  // Model: each slot holds the instruction itself; a bubble is the all-zero (illegal) instruction.
  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  function automatic logic writes(input instr_t x);
    return (x.op == R || x.op == I || x.op == LD) && x.rd != 0;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (writes(m_mem) && m_mem.rd == rs) return 2'b10;
    if (writes(m_wb) && m_wb.rd == rs)   return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_luh();
    return m_ex.op == LD && m_ex.rd != 0 && (m_ex.rd == rs1_id || m_ex.rd == rs2_id);
  endfunction

  // Packed order: pcw ifw flush | src aluop br | fa fb | mr mw | mtr rw rd_wb
  function automatic logic [19:0] model_exp();
    logic pcw, ifw, fl, src, brx;
    logic [1:0] ao;
    pcw = 1'b1; ifw = 1'b1; fl = 1'b0;
    if (hold) begin pcw = 1'b0; ifw = 1'b0; end
    else if (branch_taken_ex) fl = 1'b1;
    else if (model_luh()) begin pcw = 1'b0; ifw = 1'b0; end
    src = (m_ex.op == I || m_ex.op == LD || m_ex.op == ST);
    brx = (m_ex.op == BR);
    case (m_ex.op)
      R: ao = 2'b10;
      LD, ST: ao = 2'b01;
      BR: ao = 2'b11;
      default: ao = 2'b00;
    endcase
    return {pcw, ifw, fl, src, ao, brx, fwd(m_ex.rs1), fwd(m_ex.rs2),
            m_mem.op == LD, m_mem.op == ST, m_wb.op == LD, writes(m_wb), m_wb.rd};
  endfunction

  function automatic logic [19:0] obs();
    return {pc_write, if_id_write, if_id_flush, alu_src_ex, alu_op_ex, branch_ex, forward_a,
            forward_b, mem_read_mem, mem_write_mem, mem_to_reg_wb, reg_write_wb, rd_wb};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
  endtask

  task automatic drive(input logic h, input logic b, input logic [6:0] op,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    @(negedge clk);
    hold = h; branch_taken_ex = b; opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = d;
    #1;
  endtask

  task automatic step();
    logic stall;
    @(posedge clk);
    if (rst_n && !hold) begin
      stall = model_luh();
      m_wb  = m_mem;
      m_mem = m_ex;
      if (branch_taken_ex || stall) m_ex = '0;
      else m_ex = '{op: opcode_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id};
    end
  endtask

  task automatic cyc(input logic h, input logic b, input logic [6:0] op,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    drive(h, b, op, r1, r2, d);
    check("model", obs(), model_exp());
    step();
  endtask

  typedef struct packed {
    logic hold, br;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic pcw, ifw, fl, src;
    logic [1:0] aluop;
    logic brx;
    logic [1:0] fa, fb;
    logic mr, mw, mtr, rw;
    logic [4:0] rdwb;
  } vec_t;

  vec_t vec [13];

  initial begin
    logic [6:0] rop;
    // Expected values are read after the row's inputs settle, before the edge that latches them.
    vec[0]  = '{0,0,R, 1,2,3, 1,1,0,0,2'd0,0,2'd0,2'd0,0,0,0,0,5'd0};
    vec[1]  = '{0,0,R, 1,2,3, 1,1,0,0,2'd2,0,2'd0,2'd0,0,0,0,0,5'd0};
    vec[2]  = '{0,0,R, 3,3,4, 1,1,0,0,2'd2,0,2'd0,2'd0,0,0,0,0,5'd0};
    vec[3]  = '{0,0,LD,1,0,5, 1,1,0,0,2'd2,0,2'd2,2'd2,0,0,0,1,5'd3};
    vec[4]  = '{0,0,R, 5,2,6, 0,0,0,1,2'd1,0,2'd0,2'd0,0,0,0,1,5'd3};
    vec[5]  = '{0,0,R, 5,2,6, 1,1,0,0,2'd0,0,2'd0,2'd0,1,0,0,1,5'd4};
    vec[6]  = '{0,0,I, 0,0,0, 1,1,0,0,2'd2,0,2'd1,2'd0,0,0,1,1,5'd5};
    vec[7]  = '{0,0,R, 0,6,7, 1,1,0,1,2'd0,0,2'd0,2'd0,0,0,0,0,5'd0};
    vec[8]  = '{0,0,BR,7,6,0, 1,1,0,0,2'd2,0,2'd0,2'd1,0,0,0,1,5'd6};
    vec[9]  = '{0,0,LD,1,0,5, 1,1,0,0,2'd3,1,2'd2,2'd0,0,0,0,0,5'd0};
    vec[10] = '{0,1,R, 5,5,8, 1,1,1,1,2'd1,0,2'd0,2'd0,0,0,0,1,5'd7};
    vec[11] = '{0,0,7'd0,0,0,0, 1,1,0,0,2'd0,0,2'd0,2'd0,1,0,0,0,5'd0};
    vec[12] = '{0,0,R, 1,2,9, 1,1,0,0,2'd0,0,2'd0,2'd0,0,0,1,1,5'd5};

    // Reset with an R-type opcode waiting in ID
    model_reset();
    drive(0, 0, R, 1, 2, 1);
    check("reset_outputs", obs(), 20'hC0000);
    step();
    #1 rst_n = 1'b1;
    cyc(0, 0, R, 1, 2, 1);
    drive(0, 0, R, 2, 3, 4);
    check("reset_release_aluop", {18'd0, alu_op_ex}, {18'd0, 2'b10});
    check("model", obs(), model_exp());
    step();

    // Directed table from a clean pipeline
    drive(0, 0, 7'd0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    step();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      drive(vec[k].hold, vec[k].br, vec[k].op, vec[k].rs1, vec[k].rs2, vec[k].rd);
      check($sformatf("vec%0d", k), obs(),
            {vec[k].pcw, vec[k].ifw, vec[k].fl, vec[k].src, vec[k].aluop, vec[k].brx, vec[k].fa,
             vec[k].fb, vec[k].mr, vec[k].mw, vec[k].mtr, vec[k].rw, vec[k].rdwb});
      check("model", obs(), model_exp());
      step();
    end

    // Reset in the middle of a load-use stall drops the stall
    cyc(0, 0, LD, 1, 0, 5);
    drive(0, 0, R, 5, 2, 6);
    check("stall_before_reset", {19'd0, pc_write}, 20'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_mid_stall", obs(), 20'hC0000);
    step();
    #1 rst_n = 1'b1;
    cyc(0, 0, R, 5, 2, 6);
    drive(0, 0, ST, 6, 6, 0);
    check("after_reset_decode", {18'd0, alu_op_ex}, {18'd0, 2'b10});
    check("model", obs(), model_exp());
    step();

    // Hold for three cycles mid-stream with garbage on the ID inputs
    cyc(0, 0, R, 1, 2, 3);
    cyc(0, 0, LD, 3, 0, 4);
    cyc(0, 0, R, 4, 3, 5);
    for (int k = 0; k < 3; k++) begin
      drive(1, k[0], LD, 5, 4, 7);
      check("hold_ctrl", {17'd0, pc_write, if_id_write, if_id_flush}, 20'd0);
      check("model", obs(), model_exp());
      step();
    end
    cyc(0, 0, R, 4, 3, 5);
    cyc(0, 0, R, 5, 5, 6);
    cyc(0, 0, I, 6, 0, 7);

    // Random stream with dense register reuse to provoke hazards
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: rop = R;
        1: rop = I;
        2: rop = LD;
        3: rop = ST;
        4: rop = BR;
        default: rop = 7'($urandom_range(0, 127));
      endcase
      cyc($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12, rop,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
